// File: rtl/wb_pkg.sv
// Shared types and helpers for the round-robin Wishbone interconnect.
package wb_pkg;

  localparam int WB_DW = 32;
  localparam int WB_AW = 30;

  typedef enum logic {
    ST_IDLE,
    ST_OWNED
  } bus_state_t;

  // Width needed to hold indices 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin pick: first requester after last_gnt, wrapping.
module wb_rr_arbiter
  import wb_pkg::*;
#(
  parameter int NM = 2,
  parameter int GW = clog2(NM)
) (
  input  logic [NM-1:0] req,
  input  logic [GW-1:0] last_gnt,
  output logic [GW-1:0] next_gnt,
  output logic          valid
);

  always_comb begin
    next_gnt = last_gnt;
    valid    = 1'b0;
    for (int i = 1; i <= NM; i++) begin
      for (int j = 0; j < NM; j++) begin
        if (!valid && req[j] && (j == (int'(last_gnt) + i) % NM)) begin
          valid    = 1'b1;
          next_gnt = GW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/wb_conbus_rr.sv
// Shared-bus Wishbone interconnect: NM masters, NS slaves, round-robin
// ownership per cycle, address-decoded slave select, unmapped/timeout errors.
//   state    | meaning
//   ST_IDLE  | no owner; arbitrate among m_cyc, all strobes/acks low
//   ST_OWNED | master gnt owns the bus until it drops m_cyc
module wb_conbus_rr
  import wb_pkg::*;
#(
  parameter int NM       = 2,
  parameter int NS       = 2,
  parameter int AW       = WB_AW,
  parameter int DW       = WB_DW,
  parameter int DEC_BITS = 3,
  parameter int TIMEOUT  = 256
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic [NM*AW-1:0]       m_adr,
  input  logic [NM*DW-1:0]       m_dat_w,
  input  logic [NM*(DW/8)-1:0]   m_sel,
  input  logic [NM-1:0]          m_we,
  input  logic [NM-1:0]          m_cyc,
  input  logic [NM-1:0]          m_stb,
  output logic [DW-1:0]          m_dat_r,
  output logic [NM-1:0]          m_ack,
  output logic [NM-1:0]          m_err,
  output logic [AW-1:0]          s_adr,
  output logic [DW-1:0]          s_dat_w,
  output logic [DW/8-1:0]        s_sel,
  output logic                   s_we,
  output logic [NS-1:0]          s_cyc,
  output logic [NS-1:0]          s_stb,
  input  logic [NS*DW-1:0]       s_dat_r,
  input  logic [NS-1:0]          s_ack
);

  localparam int GW = clog2(NM);
  localparam int SW = DW / 8;
  localparam int CW = clog2(TIMEOUT + 1);

  bus_state_t          state_q, state_d;
  logic [GW-1:0]       gnt_q, gnt_d, arb_gnt;
  logic                arb_valid;
  logic [CW-1:0]       to_cnt_q;
  logic                err_q;

  logic [AW-1:0]       g_adr;
  logic [DW-1:0]       g_dat_w;
  logic [SW-1:0]       g_sel;
  logic                g_we, g_cyc, g_stb;
  logic [DEC_BITS-1:0] s_idx;
  logic                owned, mapped, act, stb_ok, to_fire;
  logic                slv_ack, ack_out, err_out;
  logic [DW-1:0]       slv_dat;

  wb_rr_arbiter #(.NM(NM), .GW(GW)) u_arb (
    .req      (m_cyc),
    .last_gnt (gnt_q),
    .next_gnt (arb_gnt),
    .valid    (arb_valid)
  );

  always_comb begin
    g_adr   = '0;
    g_dat_w = '0;
    g_sel   = '0;
    g_we    = 1'b0;
    g_cyc   = 1'b0;
    g_stb   = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (gnt_q == GW'(i)) begin
        g_adr   = m_adr[i*AW +: AW];
        g_dat_w = m_dat_w[i*DW +: DW];
        g_sel   = m_sel[i*SW +: SW];
        g_we    = m_we[i];
        g_cyc   = m_cyc[i];
        g_stb   = m_stb[i];
      end
    end
  end

  assign s_idx   = g_adr[AW-1 -: DEC_BITS];
  assign mapped  = (int'(s_idx) < NS);
  assign owned   = (state_q == ST_OWNED);
  assign act     = owned && g_cyc && g_stb;
  assign to_fire = (TIMEOUT != 0) && act && (int'(to_cnt_q) == TIMEOUT);
  // A cycle carrying an error response never also forwards a strobe or ack.
  assign stb_ok  = act && !to_fire && !err_q;
  assign ack_out = stb_ok && mapped && slv_ack;
  assign err_out = owned && g_cyc && (err_q || to_fire);

  always_comb begin
    slv_ack = 1'b0;
    slv_dat = '0;
    for (int k = 0; k < NS; k++) begin
      if (int'(s_idx) == k) begin
        slv_ack = s_ack[k];
        slv_dat = s_dat_r[k*DW +: DW];
      end
    end
  end

  always_comb begin
    s_cyc   = '0;
    s_stb   = '0;
    m_ack   = '0;
    m_err   = '0;
    s_adr   = owned ? g_adr   : '0;
    s_dat_w = owned ? g_dat_w : '0;
    s_sel   = owned ? g_sel   : '0;
    s_we    = owned && g_we;
    m_dat_r = (owned && mapped) ? slv_dat : '0;
    for (int k = 0; k < NS; k++) begin
      if (owned && mapped && int'(s_idx) == k) begin
        s_cyc[k] = g_cyc;
        s_stb[k] = stb_ok;
      end
    end
    for (int i = 0; i < NM; i++) begin
      if (gnt_q == GW'(i)) begin
        m_ack[i] = ack_out;
        m_err[i] = err_out;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          state_d = ST_OWNED;
          gnt_d   = arb_gnt;
        end
      end
      ST_OWNED: begin
        if (!g_cyc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // gnt resets to NM-1 so the first scan after reset starts at master 0.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q  <= ST_IDLE;
      gnt_q    <= GW'(NM - 1);
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      err_q   <= act && !mapped && !err_q;
      if (!owned || !g_cyc || ack_out || err_out) begin
        to_cnt_q <= '0;
      end else if (g_stb && TIMEOUT != 0) begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_conbus_rr.sv
// Directed bench for wb_conbus_rr with three masters, two slaves, 8-cycle timeout.
module tb_wb_conbus_rr;

  localparam int NM = 3;
  localparam int NS = 2;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic               sys_clk;
  logic               sys_rst_n;
  logic [NM*AW-1:0]   m_adr;
  logic [NM*DW-1:0]   m_dat_w;
  logic [NM*SW-1:0]   m_sel;
  logic [NM-1:0]      m_we, m_cyc, m_stb;
  logic [DW-1:0]      m_dat_r;
  logic [NM-1:0]      m_ack, m_err;
  logic [AW-1:0]      s_adr;
  logic [DW-1:0]      s_dat_w;
  logic [SW-1:0]      s_sel;
  logic               s_we;
  logic [NS-1:0]      s_cyc, s_stb;
  logic [NS*DW-1:0]   s_dat_r;
  logic [NS-1:0]      s_ack;

  logic [AW-1:0]      adr   [NM];
  logic [DW-1:0]      dat_w [NM];
  logic [SW-1:0]      sel   [NM];
  logic [DW-1:0]      sd0, sd1;
  logic [NS-1:0]      ack_r;
  logic               auto_ack;

  int checks;
  int failures;
  int order [4];

  assign m_adr   = {adr[2], adr[1], adr[0]};
  assign m_dat_w = {dat_w[2], dat_w[1], dat_w[0]};
  assign m_sel   = {sel[2], sel[1], sel[0]};
  assign s_dat_r = {sd1, sd0};
  // Zero-wait slaves when auto_ack is set; otherwise the bench drives ack_r.
  assign s_ack   = auto_ack ? s_stb : ack_r;

  wb_conbus_rr #(
    .NM(NM), .NS(NS), .AW(AW), .DW(DW), .DEC_BITS(2), .TIMEOUT(8)
  ) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .m_adr     (m_adr),
    .m_dat_w   (m_dat_w),
    .m_sel     (m_sel),
    .m_we      (m_we),
    .m_cyc     (m_cyc),
    .m_stb     (m_stb),
    .m_dat_r   (m_dat_r),
    .m_ack     (m_ack),
    .m_err     (m_err),
    .s_adr     (s_adr),
    .s_dat_w   (s_dat_w),
    .s_sel     (s_sel),
    .s_we      (s_we),
    .s_cyc     (s_cyc),
    .s_stb     (s_stb),
    .s_dat_r   (s_dat_r),
    .s_ack     (s_ack)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  task automatic step();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    order    = '{0, 1, 2, 0};
    sys_rst_n = 1'b0;
    auto_ack  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      adr[i]   = '0;
      dat_w[i] = '0;
      sel[i]   = '0;
    end
    m_we  = '0;
    m_cyc = 3'b001;
    m_stb = 3'b001;
    adr[0] = 30'h10;
    sd0   = 32'hAAAA_5555;
    sd1   = 32'h0;
    ack_r = 2'b01;
    #3;
    chk("rst_s_cyc", 64'(s_cyc), 0);
    chk("rst_s_stb", 64'(s_stb), 0);
    chk("rst_m_ack", 64'(m_ack), 0);
    chk("rst_m_err", 64'(m_err), 0);
    chk("rst_m_dat_r", 64'(m_dat_r), 0);
    chk("rst_s_adr", 64'(s_adr), 0);
    step();
    step();

    // m0 write to slave 0, ack on the third owned cycle
    sys_rst_n = 1'b1;
    m_we      = 3'b001;
    dat_w[0]  = 32'hDEAD_BEEF;
    sel[0]    = 4'hF;
    ack_r     = 2'b00;
    #1 chk("wr_idle_s_cyc", 64'(s_cyc), 0);
    step();
    #1;
    chk("wr_s_cyc", 64'(s_cyc), 64'b01);
    chk("wr_s_stb", 64'(s_stb), 64'b01);
    chk("wr_s_dat_w", 64'(s_dat_w), 64'hDEAD_BEEF);
    chk("wr_s_adr", 64'(s_adr), 64'h10);
    chk("wr_s_we", 64'(s_we), 1);
    chk("wr_s_sel", 64'(s_sel), 64'hF);
    chk("wr_ack_wait1", 64'(m_ack), 0);
    step();
    #1 chk("wr_ack_wait2", 64'(m_ack), 0);
    step();
    ack_r = 2'b01;
    #1;
    chk("wr_m_ack", 64'(m_ack), 64'b001);
    chk("wr_m_err", 64'(m_err), 0);
    step();
    ack_r = 2'b00;
    m_cyc = '0;
    m_stb = '0;
    m_we  = '0;
    #1;
    chk("wr_end_s_cyc", 64'(s_cyc), 0);
    chk("wr_end_m_ack", 64'(m_ack), 0);
    step();

    // m1 read of unmapped index 3
    m_cyc  = 3'b010;
    m_stb  = 3'b010;
    adr[1] = 30'h3000_0000;
    sd0    = 32'h1111_1111;
    sd1    = 32'h2222_2222;
    step();
    #1;
    chk("um_s_stb", 64'(s_stb), 0);
    chk("um_s_cyc", 64'(s_cyc), 0);
    chk("um_m_err_first", 64'(m_err), 0);
    chk("um_m_dat_r", 64'(m_dat_r), 0);
    step();
    #1;
    chk("um_m_err", 64'(m_err), 64'b010);
    chk("um_m_ack", 64'(m_ack), 0);
    step();
    #1 chk("um_m_err_gap", 64'(m_err), 0);
    step();
    #1 chk("um_m_err_repeat", 64'(m_err), 64'b010);
    step();
    m_cyc = '0;
    m_stb = '0;
    step();

    // m2 to slave 1 which never acks: error exactly 8 cycles after stb
    m_cyc  = 3'b100;
    m_stb  = 3'b100;
    adr[2] = 30'h1000_0000;
    step();
    #1;
    chk("to_s_stb_start", 64'(s_stb), 64'b10);
    chk("to_s_cyc", 64'(s_cyc), 64'b10);
    for (int k = 1; k < 8; k++) begin
      step();
      #1;
      chk("to_wait_m_err", 64'(m_err), 0);
      chk("to_wait_s_stb", 64'(s_stb), 64'b10);
    end
    step();
    #1;
    chk("to_m_err", 64'(m_err), 64'b100);
    chk("to_s_stb_gated", 64'(s_stb), 0);
    chk("to_s_cyc_held", 64'(s_cyc), 64'b10);
    step();
    #1;
    chk("to_after_err", 64'(m_err), 0);
    chk("to_s_stb_resume", 64'(s_stb), 64'b10);
    step();
    m_cyc = '0;
    m_stb = '0;
    #1 chk("to_drop_s_cyc", 64'(s_cyc), 0);
    step();

    // all three masters requesting single transfers to zero-wait slave 0
    adr[0]   = 30'h10;
    adr[1]   = 30'h10;
    adr[2]   = 30'h10;
    m_cyc    = 3'b111;
    m_stb    = 3'b111;
    auto_ack = 1'b1;
    sd0      = 32'hCAFE_0000;
    #1 chk("rr_idle_s_cyc", 64'(s_cyc), 0);
    for (int n = 0; n < 4; n++) begin
      step();
      #1;
      chk("rr_grant", 64'(m_ack), 64'(1) << order[n]);
      chk("rr_m_dat_r", 64'(m_dat_r), 64'hCAFE_0000);
      step();
      m_cyc[order[n]] = 1'b0;
      m_stb[order[n]] = 1'b0;
      #1 chk("rr_drop_s_cyc", 64'(s_cyc), 0);
      step();
      m_cyc[order[n]] = 1'b1;
      m_stb[order[n]] = 1'b1;
      #1;
      chk("rr_dead_m_ack", 64'(m_ack), 0);
      chk("rr_dead_s_cyc", 64'(s_cyc), 0);
    end

    // m2 burst interrupted by reset; m0 must win afterwards
    auto_ack = 1'b0;
    ack_r    = 2'b00;
    m_cyc    = 3'b101;
    m_stb    = 3'b101;
    adr[2]   = 30'h20;
    dat_w[2] = 32'h55AA_55AA;
    sel[2]   = 4'hF;
    m_we     = 3'b100;
    step();
    #1 chk("burst_s_adr", 64'(s_adr), 64'h20);
    step();
    ack_r = 2'b01;
    #1 chk("burst_m_ack", 64'(m_ack), 64'b100);
    step();
    #1 sys_rst_n = 1'b0;
    #1;
    chk("mrst_s_cyc", 64'(s_cyc), 0);
    chk("mrst_s_stb", 64'(s_stb), 0);
    chk("mrst_m_ack", 64'(m_ack), 0);
    chk("mrst_m_err", 64'(m_err), 0);
    chk("mrst_m_dat_r", 64'(m_dat_r), 0);
    chk("mrst_s_adr", 64'(s_adr), 0);
    chk("mrst_s_dat_w", 64'(s_dat_w), 0);
    chk("mrst_s_sel", 64'(s_sel), 0);
    chk("mrst_s_we", 64'(s_we), 0);
    #1 sys_rst_n = 1'b1;
    #1 chk("mrst_rel_s_cyc", 64'(s_cyc), 0);
    step();
    #1;
    chk("mrst_regrant_ack", 64'(m_ack), 64'b001);
    chk("mrst_regrant_adr", 64'(s_adr), 64'h10);

    // m0 aborts while slave 0 stalls; late ack must be dropped
    step();
    ack_r  = 2'b00;
    m_cyc  = 3'b011;
    m_stb  = 3'b011;
    m_we   = 3'b000;
    adr[1] = 30'h14;
    #1;
    chk("ab_stall_ack", 64'(m_ack), 0);
    chk("ab_stall_s_stb", 64'(s_stb), 64'b01);
    step();
    m_cyc[0] = 1'b0;
    m_stb[0] = 1'b0;
    ack_r    = 2'b01;
    #1;
    chk("ab_drop_s_stb", 64'(s_stb), 0);
    chk("ab_late_ack", 64'(m_ack), 0);
    step();
    #1;
    chk("ab_dead_ack", 64'(m_ack), 0);
    chk("ab_dead_s_cyc", 64'(s_cyc), 0);
    step();
    ack_r = 2'b00;
    #1;
    chk("ab_m1_s_adr", 64'(s_adr), 64'h14);
    chk("ab_m1_s_cyc", 64'(s_cyc), 64'b01);
    chk("ab_m1_ack", 64'(m_ack), 0);
    m_cyc = '0;
    m_stb = '0;
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
